// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single AXI-lite master port.
// One transaction in flight; ties alternate between requesters.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_done,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wmask,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_done,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t            state_q;
  logic              last_grant_q;  // 0 = ifu, 1 = lsu
  logic              gnt_lsu_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wmask_q;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
  logic              ifu_done_q, lsu_done_q, resp_err_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

  logic pick_lsu_d;
  logic aw_ok_d, w_ok_d;

  assign pick_lsu_d = lsu_req && (!ifu_req || !last_grant_q);
  // A channel counts as complete if it already handshook or is handshaking now.
  assign aw_ok_d    = !awvalid_q || awready;
  assign w_ok_d     = !wvalid_q  || wready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      gnt_lsu_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      ifu_done_q   <= 1'b0;
      lsu_done_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      ifu_done_q <= 1'b0;
      lsu_done_q <= 1'b0;
      resp_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ifu_req || lsu_req) begin
            gnt_lsu_q    <= pick_lsu_d;
            last_grant_q <= pick_lsu_d;
            addr_q       <= pick_lsu_d ? lsu_addr : ifu_addr;
            wdata_q      <= lsu_wdata;
            wmask_q      <= lsu_wmask;
            if (pick_lsu_d && lsu_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready_q   <= 1'b0;
            resp_err_q <= |rresp;
            if (gnt_lsu_q) begin
              lsu_rdata_q <= rdata;
              lsu_done_q  <= 1'b1;
            end else begin
              ifu_rdata_q <= rdata;
              ifu_done_q  <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        AW_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_ok_d && w_ok_d) begin
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready_q   <= 1'b0;
            resp_err_q <= |bresp;
            lsu_done_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;
  assign ifu_done  = ifu_done_q;
  assign lsu_done  = lsu_done_q;
  assign resp_err  = resp_err_q;
  assign busy      = (state_q != IDLE);
  assign araddr    = addr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = addr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wmask_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, alternation, split AW/W handshakes,
// error responses and mid-transaction reset.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] D19 = 64'hA5A5_5A5A_C3C3_3C3C;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          ifu_req;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_done;
  logic          lsu_req, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [SW-1:0] lsu_wmask;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_done, resp_err, busy;
  logic [AW-1:0] araddr, awaddr;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [SW-1:0] wstrb;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rdata(ifu_rdata), .ifu_done(ifu_done),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
    .resp_err(resp_err), .busy(busy),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge ACLK);
  endtask

  // {arvalid, awvalid, wvalid, rready, bready, ifu_done, lsu_done, busy}
  function automatic logic [63:0] ctl();
    return {56'd0, arvalid, awvalid, wvalid, rready, bready, ifu_done, lsu_done, busy};
  endfunction

  initial begin
    ARESETn = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (2) nxt();
    chk("rst_ctl", ctl(), 64'd0);
    chk("rst_ifu_rdata", ifu_rdata, 64'd0);
    chk("rst_lsu_rdata", lsu_rdata, 64'd0);
    chk("rst_resp_err", resp_err, 64'd0);

    // Single fetch, zero-wait slave
    ARESETn = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h1122_3344_5566_7788; rresp = 2'b00;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    ifu_req = 1'b1; ifu_addr = 64'h8000_0000;
    nxt();
    chk("t18_c1_arvalid", arvalid, 64'd1);
    chk("t18_c1_araddr", araddr, 64'h8000_0000);
    chk("t18_c1_busy", busy, 64'd1);
    nxt();
    chk("t18_c2_rready", rready, 64'd1);
    chk("t18_c2_arvalid", arvalid, 64'd0);
    chk("t18_c2_done", ifu_done, 64'd0);
    nxt();
    chk("t18_c3_done", ifu_done, 64'd1);
    chk("t18_c3_rdata", ifu_rdata, 64'h1122_3344_5566_7788);
    chk("t18_c3_err", resp_err, 64'd0);
    chk("t18_c3_ctl", ctl(), 64'b0000_0101);
    ifu_req = 1'b0;
    nxt();
    chk("t18_c4_ctl", ctl(), 64'd0);
    chk("t18_c4_hold", ifu_rdata, 64'h1122_3344_5566_7788);

    // Both reading from reset release: lsu, ifu, lsu
    ARESETn = 1'b0;
    ifu_req = 1'b1; ifu_addr = 64'h8000_1000;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_2000;
    rdata = D19;
    nxt();
    ARESETn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      nxt();
      chk($sformatf("t19_c%0d_ifu_done", k), ifu_done, {63'd0, k == 7});
      chk($sformatf("t19_c%0d_lsu_done", k), lsu_done, {63'd0, (k == 3) || (k == 11)});
      if (k == 1) chk("t19_first_addr", araddr, 64'h8000_2000);
      if (k == 5) chk("t19_second_addr", araddr, 64'h8000_1000);
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    nxt();
    chk("t19_idle", ctl(), 64'd0);

    // Write with awready delayed, wready immediate
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_0010;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    nxt();
    chk("t20_c1_ctl", ctl(), 64'b0110_0001);
    chk("t20_c1_awaddr", awaddr, 64'h8000_0010);
    chk("t20_c1_wdata", wdata, 64'hDEAD_BEEF);
    chk("t20_c1_wstrb", wstrb, 64'h0F);
    lsu_addr = '0; lsu_wdata = '0; lsu_wmask = 8'hFF;
    nxt();
    chk("t20_c2_ctl", ctl(), 64'b0100_0001);
    chk("t20_c2_awaddr", awaddr, 64'h8000_0010);
    nxt();
    chk("t20_c3_ctl", ctl(), 64'b0100_0001);
    chk("t20_c3_wstrb", wstrb, 64'h0F);
    nxt();
    chk("t20_c4_ctl", ctl(), 64'b0100_0001);
    awready = 1'b1;
    nxt();
    chk("t20_c5_ctl", ctl(), 64'b0000_1001);
    awready = 1'b0; bvalid = 1'b1;
    nxt();
    chk("t20_c6_ctl", ctl(), 64'b0000_0011);
    chk("t20_c6_err", resp_err, 64'd0);
    chk("t20_c6_rdata_kept", lsu_rdata, D19);
    lsu_req = 1'b0; lsu_we = 1'b0; bvalid = 1'b0;
    nxt();
    chk("t20_c7_ctl", ctl(), 64'd0);

    // Read error response; requester drops req mid-transaction
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 64'hCAFE_F00D_0BAD_1DEA;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0020;
    nxt();
    chk("t21_c1_arvalid", arvalid, 64'd1);
    chk("t21_c1_araddr", araddr, 64'h8000_0020);
    lsu_req = 1'b0;
    nxt();
    chk("t21_c2_done", lsu_done, 64'd0);
    nxt();
    chk("t21_c3_done", lsu_done, 64'd1);
    chk("t21_c3_err", resp_err, 64'd1);
    chk("t21_c3_rdata", lsu_rdata, 64'hCAFE_F00D_0BAD_1DEA);
    rresp = 2'b00;
    nxt();
    chk("t21_c4_err", resp_err, 64'd0);
    chk("t21_c4_ctl", ctl(), 64'd0);
    chk("t21_c4_hold", lsu_rdata, 64'hCAFE_F00D_0BAD_1DEA);

    // Reset while in R with rvalid pending
    rvalid = 1'b0;
    ifu_req = 1'b1; ifu_addr = 64'h8000_0040;
    nxt();
    chk("t22_c1_arvalid", arvalid, 64'd1);
    nxt();
    chk("t22_c2_ctl", ctl(), 64'b0001_0001);
    rvalid = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    chk("t22_rst_ctl", ctl(), 64'd0);
    chk("t22_rst_ifu_rdata", ifu_rdata, 64'd0);
    chk("t22_rst_lsu_rdata", lsu_rdata, 64'd0);
    ifu_req = 1'b0; rvalid = 1'b0;
    nxt();
    chk("t22_held_ctl", ctl(), 64'd0);
    ARESETn = 1'b1;
    nxt();
    chk("t22_post1_ctl", ctl(), 64'd0);
    nxt();
    chk("t22_post2_ctl", ctl(), 64'd0);
    rdata = 64'h0123_4567_89AB_CDEF; rvalid = 1'b1; rresp = 2'b00;
    ifu_req = 1'b1; ifu_addr = 64'h8000_0080;
    nxt();
    chk("t22_f_c1_araddr", araddr, 64'h8000_0080);
    nxt();
    chk("t22_f_c2_done", ifu_done, 64'd0);
    nxt();
    chk("t22_f_c3_done", ifu_done, 64'd1);
    chk("t22_f_c3_rdata", ifu_rdata, 64'h0123_4567_89AB_CDEF);
    chk("t22_f_c3_err", resp_err, 64'd0);
    ifu_req = 1'b0;
    nxt();
    chk("t22_f_c4_ctl", ctl(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 64, address width; DATA_W, 64, data width; STRB_W, DATA_W/8, write-strobe width.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- ACLK  in  1  single clock, all state on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- ifu_req  in  1  fetch read request, held until ifu_done.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rdata  out  DATA_W  fetch data, valid with ifu_done.
- ifu_done  out  1  one-cycle completion pulse.
- lsu_req  in  1  load/store request, held until lsu_done.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  STRB_W  store byte mask.
- lsu_rdata  out  DATA_W  load data, valid with lsu_done.
- lsu_done  out  1  one-cycle completion pulse.
- resp_err  out  1  nonzero RRESP/BRESP, qualified by either done.
- busy  out  1  state != IDLE.
- araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI-lite read address channel.
- rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  AXI-lite read data channel.
- awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI-lite write address channel.
- wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/STRB_W/1/1  AXI-lite write data channel.
- bresp/bvalid/bready  in/in/out  2/1/1  AXI-lite write response channel.

Function
REQ-003 States SHALL be IDLE, AR, R, AW_W, B, RESP; one transaction in flight at a time.
REQ-004 In IDLE, a single pending request SHALL be granted; both pending SHALL grant the requester not granted last (last_grant register).
REQ-005 On grant, the address, we, wdata and wmask SHALL be captured into registers; later changes to requester inputs SHALL not affect the transaction.
REQ-006 A grant SHALL move IDLE->AR for ifu or an lsu read, and IDLE->AW_W for an lsu write.
REQ-007 AR: arvalid=1 and araddr held stable until arready; on handshake SHALL move to R.
REQ-008 R: rready=1; on rvalid, rdata and rresp SHALL be captured and the FSM SHALL move to RESP.
REQ-009 AW_W: awvalid and wvalid SHALL be asserted together; each SHALL drop independently after its own handshake; the FSM SHALL move to B only once both handshakes are complete, in the same or different cycles.
REQ-010 B: bready=1; on bvalid, bresp SHALL be captured and the FSM SHALL move to RESP.
REQ-011 RESP SHALL last exactly one cycle: the granted requester's done=1, its rdata holding captured data (writes: previous value unchanged), resp_err=(resp!=0); then IDLE.
REQ-012 Minimum latency with ready/valid tied high: request sampled in IDLE cycle 0 -> done in cycle 3 for reads and cycle 3 for writes; next arbitration in cycle 4.
REQ-013 Requests arriving while busy SHALL wait and never be dropped; ifu_rdata/lsu_rdata SHALL hold their value between dones.
REQ-014 A requester dropping req mid-transaction SHALL not abort it; the transaction SHALL complete and the done pulse SHALL still be issued.
REQ-015 Outputs arvalid, awvalid, wvalid, rready and bready SHALL never be asserted in IDLE or RESP.

Reset
REQ-016 ARESETn low SHALL asynchronously force the state to IDLE, last_grant=ifu (so the first tie goes to lsu), and set all valid/ready/done/resp_err/busy outputs=0 and both rdata outputs=0.
REQ-017 A reset during any state SHALL abandon the transaction with no done pulse; after release, arbitration SHALL restart in IDLE on the first rising edge.

Verification
REQ-018 ifu_req alone, addr=0x8000_0000, slave returns 0x1122334455667788 with zero wait -> ifu_done in cycle 3, ifu_rdata=0x1122334455667788, resp_err=0.
REQ-019 ifu_req and lsu_req (read) both asserted from reset release -> lsu served first, then ifu; with both held continuously, grants alternate lsu, ifu, lsu.
REQ-020 lsu write, addr=0x8000_0010, wdata=0xDEAD_BEEF, wmask=0x0F; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; one lsu_done after bvalid; wstrb=0x0F.
REQ-021 Read with rresp=2'b10 -> lsu_done=1 with resp_err=1 in the same cycle; resp_err=0 in the next cycle.
REQ-022 ARESETn pulsed low while in R with rvalid pending -> all valid/ready outputs=0 immediately, no done; a fresh ifu_req after release completes normally.
